// File: rtl/l0_pkg.sv
// Shared constants for the L0 wavefront input buffer: read-mode encodings and
// the occupancy-counter width helper.
package l0_pkg;

    localparam logic MODE_STAGGER   = 1'b0;
    localparam logic MODE_BROADCAST = 1'b1;

    // Counter must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/l0_row_fifo.sv
// Single-clock row FIFO with a registered output word and a one-cycle valid
// pulse per pop. DEPTH must be a power of two so the pointers wrap for free.
module l0_row_fifo
    import l0_pkg::*;
#(
    parameter int BW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop_en,
    input  logic [BW-1:0] din,
    output logic [BW-1:0] dout,
    output logic          valid,
    output logic          empty,
    output logic          full
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = CW - 1;

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    // Fullness is judged before any same-cycle pop, so a pop never frees room for the push.
    assign push_ok = push & ~full;
    assign pop_ok  = pop_en & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = pop_ok;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = mem_q[rptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

    assign dout  = dout_q;
    assign valid = valid_q;

endmodule

// File: rtl/l0_wavefront.sv
// West-edge L0 buffer: ROW lockstep FIFOs read in broadcast or diagonal wavefront.
// Define L0_UNDERFLOW_FLAG_EN to add the sticky o_underflow output.
module l0_wavefront
    import l0_pkg::*;
#(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ROW*BW-1:0] in,
    input  logic              rd,
    input  logic              data_mode,
    output logic [ROW*BW-1:0] out,
    output logic [ROW-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready
`ifdef L0_UNDERFLOW_FLAG_EN
    ,
    output logic              o_underflow
`endif
);

    logic [ROW-1:0] empty, full, en;
    logic [ROW-2:0] rd_dly_q, rd_dly_d;
    logic           mode_q, mode_d;
    logic           wr_ok, idle;

    assign o_full  = |full;
    assign o_ready = &(~empty);
    // All rows advance together or not at all.
    assign wr_ok   = wr & ~o_full;
    assign idle    = ~rd & (rd_dly_q == '0);

    always_comb begin
        rd_dly_d    = rd_dly_q;
        rd_dly_d[0] = rd;
        for (int i = 1; i < ROW - 1; i++) rd_dly_d[i] = rd_dly_q[i-1];
        // Mode latches only between bursts, so a drain always finishes in its own shape.
        mode_d = idle ? data_mode : mode_q;
        en     = '0;
        en[0]  = rd;
        for (int i = 1; i < ROW; i++) en[i] = (mode_q == MODE_BROADCAST) ? rd : rd_dly_q[i-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_dly_q <= '0;
            mode_q   <= MODE_STAGGER;
        end else begin
            rd_dly_q <= rd_dly_d;
            mode_q   <= mode_d;
        end
    end

    for (genvar g = 0; g < ROW; g++) begin : g_row
        l0_row_fifo #(.BW(BW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (reset),
            .push  (wr_ok),
            .pop_en(en[g]),
            .din   (in[g*BW +: BW]),
            .dout  (out[g*BW +: BW]),
            .valid (o_valid[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

`ifdef L0_UNDERFLOW_FLAG_EN
    logic uf_q, uf_d;

    assign uf_d = uf_q | (|(en & empty));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) uf_q <= 1'b0;
        else        uf_q <= uf_d;
    end

    assign o_underflow = uf_q;
`endif

endmodule

// File: tb/tb_l0_wavefront.sv
// Randomised and directed bench for l0_wavefront against a queue-based model
// of per-row FIFOs driven by the rd history.
module tb_l0_wavefront;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr, rd, data_mode;
    logic [ROW*BW-1:0] din, dout;
    logic [ROW-1:0]    o_valid;
    logic              o_full, o_ready;
`ifdef L0_UNDERFLOW_FLAG_EN
    logic              o_underflow;
`endif

    int tests = 0;
    int fails = 0;

    // Model: one queue per row, the rd values of previous cycles, and the latched mode.
    logic [BW-1:0]     q [ROW][$];
    logic [ROW*BW-1:0] m_out;
    logic [ROW-1:0]    m_vld;
    logic [ROW-1:0]    m_age;
    logic              m_mode;
    logic              m_uf;

    always #5 clk = ~clk;

    l0_wavefront #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .in       (din),
        .rd       (rd),
        .data_mode(data_mode),
        .out      (dout),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready)
`ifdef L0_UNDERFLOW_FLAG_EN
        ,
        .o_underflow(o_underflow)
`endif
    );

    function automatic logic m_ready();
        m_ready = 1'b1;
        for (int i = 0; i < ROW; i++) if (q[i].size() == 0) m_ready = 1'b0;
    endfunction

    function automatic logic m_full();
        m_full = 1'b0;
        for (int i = 0; i < ROW; i++) if (q[i].size() == DEPTH) m_full = 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ROW; i++) q[i].delete();
        m_out  = '0;
        m_vld  = '0;
        m_age  = '0;
        m_mode = 1'b0;
        m_uf   = 1'b0;
    endtask

    // Drives one clock of stimulus, advances the model, returns at posedge+1.
    task automatic cycle(input logic w, input logic [ROW*BW-1:0] d, input logic r, input logic dm);
        logic full_now, idle, en;
        wr = w; din = d; rd = r; data_mode = dm;
        full_now = m_full();
        idle = ~r && (m_age == '0);
        for (int i = 0; i < ROW; i++) begin
            en = (m_mode || i == 0) ? r : m_age[i];
            if (en && q[i].size() > 0) begin
                m_out[i*BW +: BW] = q[i].pop_front();
                m_vld[i] = 1'b1;
            end else begin
                m_vld[i] = 1'b0;
                if (en) m_uf = 1'b1;
            end
        end
        if (w && !full_now) for (int i = 0; i < ROW; i++) q[i].push_back(d[i*BW +: BW]);
        if (idle) m_mode = dm;
        m_age = m_age << 1;
        m_age[1] = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; wr = 1'b0; rd = 1'b0; data_mode = 1'b0; din = '0;
        model_clear();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr = 1'b0; rd = 1'b0; data_mode = 1'b0; din = '0;
        model_clear();
        #2;
        if ({dout, o_valid, o_full, o_ready} !== '0) begin
            fails++; $display("FAIL reset_outputs got %h/%b/%b/%b exp 0", dout, o_valid, o_full, o_ready);
        end
        tests++;
`ifdef L0_UNDERFLOW_FLAG_EN
        if (o_underflow !== 1'b0) begin fails++; $display("FAIL reset_uf got %b exp 0", o_underflow); end
        tests++;
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        if ({o_valid, o_ready} !== '0) begin
            fails++; $display("FAIL reset_release got %b/%b exp 0", o_valid, o_ready);
        end
        tests++;
    endtask

    task automatic test_stagger();
        logic [ROW*BW-1:0] d;
        int first0, first7, n;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < ROW; i++) d[i*BW +: BW] = BW'(i + 1 + 2 * w);
            cycle(1'b1, d, 1'b0, 1'b0);
        end
        first0 = -1; first7 = -1;
        for (n = 1; n <= 14; n++) begin
            cycle(1'b0, '0, (n <= 3), 1'b0);
            if (o_valid[0] && first0 < 0) first0 = n;
            if (o_valid[7] && first7 < 0) first7 = n;
            if ({o_valid, dout} !== {m_vld, m_out}) begin
                fails++; $display("FAIL stagger_data c%0d got %b/%h exp %b/%h", n, o_valid, dout, m_vld, m_out);
            end
            if ({o_ready, o_full} !== {m_ready(), m_full()}) begin
                fails++; $display("FAIL stagger_flags c%0d got %b%b exp %b%b", n, o_ready, o_full, m_ready(), m_full());
            end
            tests += 2;
        end
        if (first0 != 1 || first7 != 8) begin
            fails++; $display("FAIL stagger_diag got row0@%0d row7@%0d exp 1/8", first0, first7);
        end
        tests++;
    endtask

    task automatic test_broadcast();
        logic [ROW*BW-1:0] d;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < ROW; i++) d[i*BW +: BW] = BW'(i + 1 + 2 * w);
            cycle(1'b1, d, 1'b0, 1'b1);
        end
        for (int n = 1; n <= 10; n++) begin
            cycle(1'b0, '0, (n <= 3), 1'b1);
            if (n <= 3 && o_valid !== '1) begin
                fails++; $display("FAIL bcast_allvalid c%0d got %b exp all ones", n, o_valid);
            end
            if ({o_valid, dout} !== {m_vld, m_out}) begin
                fails++; $display("FAIL bcast_data c%0d got %b/%h exp %b/%h", n, o_valid, dout, m_vld, m_out);
            end
            if ({o_ready, o_full} !== {m_ready(), m_full()}) begin
                fails++; $display("FAIL bcast_flags c%0d got %b%b exp %b%b", n, o_ready, o_full, m_ready(), m_full());
            end
            tests += (n <= 3) ? 3 : 2;
        end
    endtask

    task automatic test_full();
        logic [ROW*BW-1:0] d;
        do_reset();
        for (int w = 0; w < DEPTH + 1; w++) begin
            for (int i = 0; i < ROW; i++) d[i*BW +: BW] = BW'(w + i);
            cycle(1'b1, d, 1'b0, 1'b1);
            if (o_full !== (w >= DEPTH - 1)) begin
                fails++; $display("FAIL full_flag w%0d got %b exp %b", w, o_full, (w >= DEPTH - 1));
            end
            tests++;
        end
        for (int n = 0; n < DEPTH + 2; n++) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            if ({o_valid, dout} !== {m_vld, m_out}) begin
                fails++; $display("FAIL full_drain p%0d got %b/%h exp %b/%h", n, o_valid, dout, m_vld, m_out);
            end
            if ({o_ready, o_full} !== {m_ready(), m_full()}) begin
                fails++; $display("FAIL full_flags p%0d got %b%b exp %b%b", n, o_ready, o_full, m_ready(), m_full());
            end
            tests += 2;
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_mode_switch();
        logic [ROW*BW-1:0] d;
        do_reset();
        for (int w = 0; w < 4; w++) begin
            d = ROW*BW'($urandom());
            cycle(1'b1, d, 1'b0, 1'b0);
        end
        for (int n = 0; n < 24; n++) begin
            d = ROW*BW'($urandom());
            cycle((n >= 12 && n < 14), d, (n < 4) || (n >= 16 && n < 18), (n >= 2));
            if ({o_valid, dout} !== {m_vld, m_out}) begin
                fails++; $display("FAIL mode_data c%0d got %b/%h exp %b/%h", n, o_valid, dout, m_vld, m_out);
            end
            if ({o_ready, o_full} !== {m_ready(), m_full()}) begin
                fails++; $display("FAIL mode_flags c%0d got %b%b exp %b%b", n, o_ready, o_full, m_ready(), m_full());
            end
            tests += 2;
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b1, ROW*BW'(32'h1234_5678), 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, '0, (n < 2), 1'b1);
            if ({o_valid, dout} !== {m_vld, m_out}) begin
                fails++; $display("FAIL uflow_data c%0d got %b/%h exp %b/%h", n, o_valid, dout, m_vld, m_out);
            end
            tests++;
`ifdef L0_UNDERFLOW_FLAG_EN
            if (o_underflow !== m_uf) begin
                fails++; $display("FAIL uflow_flag c%0d got %b exp %b", n, o_underflow, m_uf);
            end
            tests++;
`endif
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int w = 0; w < 8; w++) cycle(1'b1, ROW*BW'($urandom()), 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) cycle(1'b0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        #2;
        if ({dout, o_valid, o_full, o_ready} !== '0) begin
            fails++; $display("FAIL midreset_outputs got %h/%b/%b/%b exp 0", dout, o_valid, o_full, o_ready);
        end
        tests++;
`ifdef L0_UNDERFLOW_FLAG_EN
        if (o_underflow !== 1'b0) begin fails++; $display("FAIL midreset_uf got %b exp 0", o_underflow); end
        tests++;
`endif
        model_clear();
        rd = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 9; n++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            if ({o_valid, o_ready, dout} !== {m_vld, m_ready(), m_out}) begin
                fails++; $display("FAIL midreset_after c%0d got %b/%b/%h exp %b/%b/%h", n, o_valid, o_ready, dout, m_vld, m_ready(), m_out);
            end
            tests++;
        end
    endtask

    task automatic test_random();
        int burst = 0;
        logic dm = 1'b0;
        logic r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (burst > 0) begin
                r = 1'b1; burst--;
            end else if ($urandom_range(3) == 0) begin
                r = 1'b1; burst = $urandom_range(7);
            end else begin
                r = 1'b0;
            end
            if ($urandom_range(7) == 0) dm = ~dm;
            cycle(($urandom_range(2) != 0), ROW*BW'($urandom()), r, dm);
            if ({o_valid, dout} !== {m_vld, m_out}) begin
                fails++; $display("FAIL rand_data c%0d got %b/%h exp %b/%h", n, o_valid, dout, m_vld, m_out);
            end
            if ({o_ready, o_full} !== {m_ready(), m_full()}) begin
                fails++; $display("FAIL rand_flags c%0d got %b%b exp %b%b", n, o_ready, o_full, m_ready(), m_full());
            end
            tests += 2;
`ifdef L0_UNDERFLOW_FLAG_EN
            if (o_underflow !== m_uf) begin
                fails++; $display("FAIL rand_uf c%0d got %b exp %b", n, o_underflow, m_uf);
            end
            tests++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_broadcast();
        test_full();
        test_mode_switch();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l0_wavefront.md
# l0_wavefront

Parametrised successor to the L0 input buffer that feeds the west edge of the 2D systolic array. Holds one synchronous FIFO per array row, written in lockstep from a packed ROW×BW vector. Reads either all rows together (broadcast) or as a true diagonal wavefront: row i follows row 0 by exactly i cycles for the whole burst, including drain. Adds per-row output valids, configurable depth, safe mode switching and a clarified ready/full contract.

## Interface
- ROW, 8, number of rows/FIFOs (≥2)
- BW, 4, bits per row element
- DEPTH, 16, entries per row FIFO (power of 2, ≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- wr  in  1  write request; pushes in[] into every row FIFO
- in  in  ROW*BW  packed write data, row i at [BW*(i+1)-1 : BW*i]
- rd  in  1  read request; held high for the length of a burst
- data_mode  in  1  1 = broadcast (all rows read together), 0 = staggered wavefront
- out  out  ROW*BW  registered read data, same packing as in
- o_valid  out  ROW  per-row: out slice updated with a popped word this cycle
- o_full  out  1  OR of per-row full
- o_ready  out  1  AND of per-row non-empty (every row holds ≥1 word)
- o_underflow  out  1  sticky underflow flag (only with L0_UNDERFLOW_FLAG_EN)

## Operation
- Write: on an edge with wr=1 and o_full=0, every row pushes its slice. With wr=1 and o_full=1 the write is dropped for all rows; no row may advance alone. A same-cycle pop does not make room for the push.
- Mode register mode_q loads data_mode only when idle (rd=0 and the stagger delay line is all zero); otherwise data_mode is ignored. A mode change never splits a burst.
- Per-row enable en[i]: broadcast → en[i]=rd; staggered → en[0]=rd, en[i]=rd_dly[i-1], where rd_dly is a ROW-1 stage shift register of rd (rd_dly[0]=rd delayed 1 cycle).
- Pop: row i pops on an edge where en[i]=1 and the row is non-empty. out slice i takes the word and o_valid[i]=1 for the following cycle.
- en[i]=1 on an empty row: no pop, o_valid[i]=0, out slice holds its last value; this is an underflow event.
- Simultaneous push and pop on a non-full, non-empty row: both occur; occupancy unchanged.
- Occupancy per row: log2(DEPTH)+1-bit counter; full at DEPTH, empty at 0. Pointers wrap modulo DEPTH.

## Timing
- Reset (reset=0, async): FIFOs empty, pointers/counters 0, rd_dly=0, mode_q=0 (staggered), out=0, o_valid=0, o_full=0, o_ready=0, o_underflow=0.
- Write-to-read: a word pushed at edge k is poppable at edge k+1; o_ready rises after edge k.
- Read latency: rd sampled high at edge k → row i valid after edge k (broadcast) or after edge k+i (staggered).
- Burst of N cycles of rd in staggered mode: row i is valid in cycles k+i .. k+i+N-1. The array sees a clean diagonal at entry and at drain.
- o_full and o_ready are combinational from counters, not registered.
- Reset asserted mid-burst: all state clears immediately; the burst is not resumed.

## Configuration
- L0_UNDERFLOW_FLAG_EN defined: o_underflow port exists and is set by any underflow event. It stays set until reset.
- Not defined: port and logic are absent; underflow behaviour on out/o_valid is unchanged.

## Structure
- Package l0_pkg: mode constants MODE_STAGGER=1'b0, MODE_BROADCAST=1'b1, plus a function computing the counter width from DEPTH.
- Sub-module l0_row_fifo (BW, DEPTH): single-clock FIFO with push, pop, out register, valid, empty, full. Instantiated ROW times in a generate loop. Stagger line, mode register and flag logic live at top level.

## Test plan
- Reset then 3 writes (row i = 4'(i+1), then +2, +4), mode 0, rd high 3 cycles → row 0 valid cycles 1–3, row 7 valid cycles 8–10, values in write order.
- Same data, mode 1, rd high 3 cycles → all o_valid high cycles 1–3 together; o_ready drops after the third pop.
- Write DEPTH=16 words → o_full=1; a 17th write is dropped in every row; 16 pops return words 0..15 then rows are empty.
- Toggle data_mode from 0 to 1 in the middle of a staggered burst → burst completes staggered; the next burst is broadcast.
- With the macro defined, rd for 2 cycles with 1 word stored → second cycle o_valid=0, out holds, o_underflow=1 until reset. Without the macro, out/o_valid behave identically.
- Assert reset on cycle 4 of an 8-row staggered burst → all outputs 0 asynchronously; after release o_ready=0.
